cc_microseq_control: RTL and testbench

//  Microprogram sequencer for the microcoded datapath. Holds the control-store address register (CSAR),

---
 rtl/cc_microseq_control.sv | 129 ++++++++++++
 tb/tb_cc_microseq_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cc_microseq_control.sv
// Microprogram sequencer: control-store address register (CSAR), incrementer,
// processor status register (PSR) and microaddress mux select decode.
// Optional trace counters are compiled in when CC_USEQ_TRACE_EN is defined.
module cc_microseq_control #(
  parameter int DATAWIDTH_ADDR = 11,
  parameter int DATAWIDTH_COND = 3,
  parameter int DATAWIDTH_SEL  = 2
) (
  input  logic                      CC_USEQ_CLOCK_50,
  input  logic                      CC_USEQ_RESET_InHigh,
  input  logic [DATAWIDTH_ADDR-1:0] CC_USEQ_Addr_InBUS,
  input  logic [DATAWIDTH_COND-1:0] CC_USEQ_Cond_InBUS,
  input  logic [3:0]                CC_USEQ_Flags_InBUS,
  input  logic                      CC_USEQ_FlagLoad_In,
  input  logic                      CC_USEQ_IR13_In,
  input  logic                      CC_USEQ_Hold_In,
  output logic [DATAWIDTH_ADDR-1:0] CC_USEQ_Addr_OutBUS,
  output logic [DATAWIDTH_ADDR-1:0] CC_USEQ_Next_OutBUS,
  output logic [DATAWIDTH_SEL-1:0]  CC_USEQ_Sel_OutBUS,
  output logic [3:0]                CC_USEQ_Psr_OutBUS
`ifdef CC_USEQ_TRACE_EN
  ,
  output logic [15:0]               CC_USEQ_Count_OutBUS,
  output logic                      CC_USEQ_Taken_Out
`endif
);

  // MIR COND field encodings
  typedef enum logic [DATAWIDTH_COND-1:0] {
    COND_NEXT   = 3'd0,
    COND_N      = 3'd1,
    COND_Z      = 3'd2,
    COND_V      = 3'd3,
    COND_C      = 3'd4,
    COND_IR13   = 3'd5,
    COND_JUMP   = 3'd6,
    COND_DECODE = 3'd7
  } cond_t;

  // Microaddress mux channel select
  typedef enum logic [DATAWIDTH_SEL-1:0] {
    SEL_NEXT   = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_DECODE = 2'b10
  } sel_t;

  // PSR bit positions within {n,z,v,c}
  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  logic [DATAWIDTH_ADDR-1:0] csar_q, csar_d;
  logic [3:0]                psr_q, psr_d;
  cond_t                     cond;
  sel_t                      sel;

  assign cond = cond_t'(CC_USEQ_Cond_InBUS);

  // Select decode: branches test the registered PSR, so a same-cycle flag load is not visible
  always_comb begin
    sel = SEL_NEXT;
    case (cond)
      COND_NEXT:   sel = SEL_NEXT;
      COND_N:      sel = psr_q[PSR_N]   ? SEL_JUMP : SEL_NEXT;
      COND_Z:      sel = psr_q[PSR_Z]   ? SEL_JUMP : SEL_NEXT;
      COND_V:      sel = psr_q[PSR_V]   ? SEL_JUMP : SEL_NEXT;
      COND_C:      sel = psr_q[PSR_C]   ? SEL_JUMP : SEL_NEXT;
      COND_IR13:   sel = CC_USEQ_IR13_In ? SEL_JUMP : SEL_NEXT;
      COND_JUMP:   sel = SEL_JUMP;
      COND_DECODE: sel = SEL_DECODE;
      default:     sel = SEL_NEXT;
    endcase
  end

  // Next-state for CSAR (frozen while held) and PSR (loads independently of hold)
  always_comb begin
    csar_d = csar_q;
    psr_d  = psr_q;
    if (!CC_USEQ_Hold_In)    csar_d = CC_USEQ_Addr_InBUS;
    if (CC_USEQ_FlagLoad_In) psr_d  = CC_USEQ_Flags_InBUS;
  end

  // CSAR and PSR registers
  always_ff @(posedge CC_USEQ_CLOCK_50 or posedge CC_USEQ_RESET_InHigh) begin
    if (CC_USEQ_RESET_InHigh) begin
      csar_q <= '0;
      psr_q  <= '0;
    end else begin
      csar_q <= csar_d;
      psr_q  <= psr_d;
    end
  end

  assign CC_USEQ_Addr_OutBUS = csar_q;
  assign CC_USEQ_Next_OutBUS = csar_q + DATAWIDTH_ADDR'(1);
  assign CC_USEQ_Sel_OutBUS  = sel;
  assign CC_USEQ_Psr_OutBUS  = psr_q;

`ifdef CC_USEQ_TRACE_EN
  logic [15:0] count_q, count_d;
  logic        taken_q, taken_d;

  // Trace next-state: count CSAR loads, remember whether the load came from a non-Next channel
  always_comb begin
    count_d = count_q;
    taken_d = taken_q;
    if (!CC_USEQ_Hold_In) begin
      count_d = count_q + 16'd1;
      taken_d = (sel != SEL_NEXT);
    end
  end

  // Trace registers
  always_ff @(posedge CC_USEQ_CLOCK_50 or posedge CC_USEQ_RESET_InHigh) begin
    if (CC_USEQ_RESET_InHigh) begin
      count_q <= '0;
      taken_q <= 1'b0;
    end else begin
      count_q <= count_d;
      taken_q <= taken_d;
    end
  end

  assign CC_USEQ_Count_OutBUS = count_q;
  assign CC_USEQ_Taken_Out    = taken_q;
`endif

endmodule

// File: tb/tb_cc_microseq_control.sv
// Scoreboard bench for cc_microseq_control: a driver closes the microaddress
// mux loop from a behavioural model and queues expected outputs; a monitor
// compares them against the DUT once per cycle.
module tb_cc_microseq_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr_in = '0;
  logic [2:0]  cond = '0;
  logic [3:0]  flags = '0;
  logic        flag_load = 1'b0;
  logic        ir13 = 1'b0;
  logic        hold = 1'b0;
  logic [10:0] addr_out, next_out;
  logic [1:0]  sel_out;
  logic [3:0]  psr_out;
`ifdef CC_USEQ_TRACE_EN
  logic [15:0] count_out;
  logic        taken_out;
`endif

  always #5 clk = ~clk;

  cc_microseq_control #(
    .DATAWIDTH_ADDR(11),
    .DATAWIDTH_COND(3),
    .DATAWIDTH_SEL (2)
  ) dut (
    .CC_USEQ_CLOCK_50    (clk),
    .CC_USEQ_RESET_InHigh(rst),
    .CC_USEQ_Addr_InBUS  (addr_in),
    .CC_USEQ_Cond_InBUS  (cond),
    .CC_USEQ_Flags_InBUS (flags),
    .CC_USEQ_FlagLoad_In (flag_load),
    .CC_USEQ_IR13_In     (ir13),
    .CC_USEQ_Hold_In     (hold),
    .CC_USEQ_Addr_OutBUS (addr_out),
    .CC_USEQ_Next_OutBUS (next_out),
    .CC_USEQ_Sel_OutBUS  (sel_out),
    .CC_USEQ_Psr_OutBUS  (psr_out)
`ifdef CC_USEQ_TRACE_EN
    ,
    .CC_USEQ_Count_OutBUS(count_out),
    .CC_USEQ_Taken_Out   (taken_out)
`endif
  );

  typedef struct {
    int unsigned addr;
    int unsigned next;
    int unsigned sel;
    int unsigned psr;
    int unsigned count;
    int unsigned taken;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state, kept as plain integers
  int unsigned m_csar  = 0;
  int unsigned m_psr   = 0;
  int unsigned m_count = 0;
  int unsigned m_taken = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel choice from the sequencing rules: 0 next, 1 jump, 2 decode
  function automatic int unsigned model_sel(input int unsigned c, input int unsigned psr, input int unsigned i13);
    if (c == 0) return 0;
    if (c >= 1 && c <= 4) return (psr >> (4 - c)) & 1;  // n,z,v,c in descending bit order
    if (c == 5) return i13;
    if (c == 6) return 1;
    return 2;
  endfunction

  // One microcycle: apply inputs, close the mux from the model, queue expectation, advance model
  task automatic cycle(input bit r, input int unsigned c, input int unsigned f, input bit fl,
                       input bit i13, input bit h, input int unsigned jmp, input int unsigned dec);
    int unsigned s, mux;
    exp_t e;
    @(negedge clk);
    rst = r; cond = 3'(c); flags = 4'(f); flag_load = fl; ir13 = i13; hold = h;
    if (r) begin
      m_csar = 0; m_psr = 0; m_count = 0; m_taken = 0;
    end
    s   = model_sel(c, m_psr, i13);
    mux = (s == 0) ? (m_csar + 1) % 2048 : (s == 1) ? jmp % 2048 : dec % 2048;
    addr_in = 11'(mux);
    #1;
    e.addr = m_csar; e.next = (m_csar + 1) % 2048; e.sel = s;
    e.psr = m_psr; e.count = m_count; e.taken = m_taken;
    q.push_back(e);
    if (!r) begin
      if (!h) begin
        m_csar  = mux;
        m_count = (m_count + 1) % 65536;
        m_taken = (s != 0) ? 1 : 0;
      end
      if (fl) m_psr = f;
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation each cycle
  always @(negedge clk) begin
    #3;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("addr", addr_out, e.addr);
      check("next", next_out, e.next);
      check("sel",  sel_out,  e.sel);
      check("psr",  psr_out,  e.psr);
`ifdef CC_USEQ_TRACE_EN
      check("count", count_out, e.count);
      check("taken", taken_out, e.taken);
`endif
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then closed-loop increment 1,2,3
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset pulse mid-run, then count up again
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // z loaded 1, then branch on z taken to 0x1A0
    cycle(0, 0, 4'b0100, 1, 0, 0, 0, 0);
    cycle(0, 2, 0, 0, 0, 0, 11'h1A0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // z loaded 0, branch on z not taken
    cycle(0, 0, 4'b0000, 1, 0, 0, 0, 0);
    cycle(0, 2, 0, 0, 0, 0, 11'h1A0, 0);
    // Same-cycle flag load with branch on n sees old n, next cycle sees new n
    cycle(0, 1, 4'b1000, 1, 0, 0, 11'h055, 0);
    cycle(0, 1, 0, 0, 0, 0, 11'h2AA, 0);
    // Decode dispatch, then unconditional jump irrespective of PSR
    cycle(0, 7, 0, 0, 0, 0, 11'h123, 11'h4C0);
    cycle(0, 6, 0, 0, 0, 0, 11'h321, 11'h4C0);
    // CSAR wrap 2047 -> 0
    cycle(0, 6, 0, 0, 0, 0, 11'h7FF, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // Hold for 3 edges while PSR still loads
    cycle(0, 0, 4'b1010, 1, 0, 1, 0, 0);
    cycle(0, 0, 4'b0101, 1, 0, 1, 0, 0);
    cycle(0, 4, 4'b1111, 1, 0, 1, 11'h111, 0);
    cycle(0, 4, 0, 0, 0, 0, 11'h111, 0);
    // IR13 conditional both ways
    cycle(0, 5, 0, 0, 1, 0, 11'h600, 0);
    cycle(0, 5, 0, 0, 0, 0, 11'h600, 0);
    // Randomized run with occasional resets and holds
    for (int unsigned i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
            $urandom_range(0, 2047), $urandom_range(0, 2047));
    end
    repeat (3) @(negedge clk);
    #5;
    check("queue_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
